// File: rtl/debug_loader.sv
// -----------------------------------------------------------------------------
// debug_loader
//
// Bring-up sequencer for a small core. It optionally zeroes instruction
// memory, accepts a stream of instruction words into IMEM, releases the
// core from reset for a programmed number of cycles, then streams out the
// first DUMP_REGS entries of the core register file. It finally parks in
// DONE until the next reset.
//
// Build option:
//   DBG_LOADER_CLEAR_EN  when defined, every reset is followed by a CLEAR
//                        phase. That phase writes zero to IMEM[0..IMEM_DEPTH-1],
//                        one word per cycle, before loading is allowed.
//                        When undefined, no CLEAR logic is built.
//
// Ports:
//   CLOCK_50                 sole clock, rising edge
//   RSTN_N                   asynchronous active-low reset
//   ld_valid / ld_ready      load word handshake
//   ld_addr  [AW:0]          target IMEM index; one bit wider than the IMEM
//                            index so out-of-range targets can be presented
//                            and dropped
//   ld_data  [XLEN-1:0]      instruction word
//   ld_last                  final load word
//   run_cycles [15:0]        core run length, sampled with the last word
//   imem_we/waddr/wdata      IMEM write port (registered)
//   core_rstn                active-low core reset, high only while running
//   reg_raddr [RW-1:0]       core register file read index
//   reg_rdata [XLEN-1:0]     combinational register file read data
//   dump_valid / dump_ready  register dump handshake
//   dump_idx  [RW-1:0]       register index carried by dump_data
//   dump_data [XLEN-1:0]     register value
//   done                     whole sequence complete
// -----------------------------------------------------------------------------
module debug_loader #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int NREGS      = 32,
    parameter int DUMP_REGS  = 10,
    localparam int AW        = $clog2(IMEM_DEPTH),
    localparam int LAW       = AW + 1,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic            CLOCK_50,
    input  logic            RSTN_N,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [LAW-1:0]  ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    input  logic [15:0]     run_cycles,
    output logic            imem_we,
    output logic [AW-1:0]   imem_waddr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_rstn,
    output logic [RW-1:0]   reg_raddr,
    input  logic [XLEN-1:0] reg_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [RW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            done
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

`ifdef DBG_LOADER_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
    localparam int     CW        = $clog2(IMEM_DEPTH + 1);
`else
    localparam state_t RST_STATE = ST_LOAD;
`endif

    localparam logic [RW-1:0] LAST_IDX = RW'(DUMP_REGS - 1);

    state_t            state_q, state_d;
    logic              ld_ready_q, ld_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [AW-1:0]     imem_waddr_q, imem_waddr_d;
    logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
    logic [15:0]       run_len_q, run_len_d;
    logic [15:0]       run_cnt_q, run_cnt_d;
    logic [RW-1:0]     idx_q, idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic [RW-1:0]     dump_idx_q, dump_idx_d;
    logic [XLEN-1:0]   dump_data_q, dump_data_d;
`ifdef DBG_LOADER_CLEAR_EN
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
`endif

    // State and datapath registers. Everything visible on a port is cleared
    // asynchronously so a mid-run reset takes effect without a clock.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            state_q      <= RST_STATE;
            ld_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            run_len_q    <= '0;
            run_cnt_q    <= '0;
            idx_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
`ifdef DBG_LOADER_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= ld_ready_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            run_len_q    <= run_len_d;
            run_cnt_q    <= run_cnt_d;
            idx_q        <= idx_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
`ifdef DBG_LOADER_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        run_len_d    = run_len_q;
        run_cnt_d    = run_cnt_q;
        idx_d        = idx_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
`ifdef DBG_LOADER_CLEAR_EN
        clr_cnt_d    = clr_cnt_q;
`endif

        case (state_q)
            ST_CLEAR: begin
`ifdef DBG_LOADER_CLEAR_EN
                // The counter runs one past the last index so the final zero
                // write is already on the port before LOAD opens.
                if (clr_cnt_q < CW'(IMEM_DEPTH)) begin
                    imem_we_d    = 1'b1;
                    imem_waddr_d = clr_cnt_q[AW-1:0];
                    imem_wdata_d = '0;
                    clr_cnt_d    = clr_cnt_q + CW'(1);
                end else begin
                    state_d = ST_LOAD;
                end
`else
                state_d = ST_LOAD;
`endif
            end

            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    // Out-of-range targets are consumed but never written.
                    if (ld_addr < LAW'(IMEM_DEPTH)) begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = ld_addr[AW-1:0];
                        imem_wdata_d = ld_data;
                    end
                    if (ld_last) begin
                        run_len_d = run_cycles;
                        run_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Leave on the edge that ends the last running cycle, so
                // core_rstn falls exactly as DUMP begins. A zero length
                // spends one cycle here with the core still held.
                if (run_len_q == 16'd0 || run_cnt_q == run_len_q - 16'd1) begin
                    state_d      = ST_DUMP;
                    idx_d        = '0;
                    dump_valid_d = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
            end

            ST_DUMP: begin
                if (!dump_valid_q) begin
                    // reg_raddr has been stable on idx_q for this whole cycle.
                    dump_data_d  = reg_rdata;
                    dump_idx_d   = idx_q;
                    dump_valid_d = 1'b1;
                end else if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + RW'(1);
                    end
                end
            end

            ST_DONE: begin
                dump_valid_d = 1'b0;
            end

            default: begin
                state_d = RST_STATE;
            end
        endcase

        // Registered so ld_ready stays low through reset and any CLEAR phase.
        ld_ready_d = (state_d == ST_LOAD);
    end

    assign ld_ready   = ld_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    // Decoded from state so an asynchronous reset drops it at once.
    assign core_rstn  = (state_q == ST_RUN) && (run_len_q != 16'd0);
    assign reg_raddr  = (state_q == ST_DUMP) ? idx_q : '0;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_loader.sv
module tb_debug_loader;

    logic        CLOCK_50 = 1'b0;
    logic        RSTN_N = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic [15:0] run_cycles = '0;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rstn;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        done;

    int total = 0;
    int bad = 0;

    debug_loader #(
        .XLEN(32), .IMEM_DEPTH(32), .NREGS(32), .DUMP_REGS(10)
    ) dut (
        .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .run_cycles(run_cycles),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rstn(core_rstn), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .done(done)
    );

    // Register file model: reg[i] = i * 0x11, combinational read.
    assign reg_rdata = 32'(reg_raddr) * 32'h11;

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        int c;
        ld_valid = 1'b0; ld_last = 1'b0; dump_ready = 1'b0;
        RSTN_N = 1'b0;
        tick(); tick();
        RSTN_N = 1'b1;
        c = 0;
        while (ld_ready !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_to_load: ld_ready=%b after %0d cycles, want 1", ld_ready, c);
        end
    endtask

    task automatic test_reset();
        #3 RSTN_N = 1'b0;
        #2;
        total++;
        if ({ld_ready, imem_we, core_rstn, dump_valid, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes: ready/we/crst/dv/done=%b want 00000",
                     {ld_ready, imem_we, core_rstn, dump_valid, done});
        end
        total++;
        if (imem_waddr !== 5'd0 || imem_wdata !== 32'd0 || reg_raddr !== 5'd0) begin
            bad++;
            $display("FAIL reset_imem: waddr=%0d wdata=%h raddr=%0d want 0 0 0",
                     imem_waddr, imem_wdata, reg_raddr);
        end
        total++;
        if (dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_dump: idx=%0d data=%h want 0 0", dump_idx, dump_data);
        end
        tick(); tick();
        total++;
        if (ld_ready !== 1'b0 || core_rstn !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: ld_ready=%b core_rstn=%b want 0 0", ld_ready, core_rstn);
        end
    endtask

    task automatic test_load_run();
        int hi;
        int we_extra;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_addr = 6'(3 + i);
            ld_data = 32'hCC10_8000 + 32'(i);
            ld_last = (i == 2);
            run_cycles = 16'd100;
            total++;
            if (ld_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready[%0d]: got %b want 1", i, ld_ready);
            end
            tick();
            total++;
            if (imem_we !== 1'b1 || imem_waddr !== 5'(3 + i) || imem_wdata !== 32'hCC10_8000 + 32'(i)) begin
                bad++;
                $display("FAIL load_write[%0d]: we=%b addr=%0d data=%h want 1 %0d %h",
                         i, imem_we, imem_waddr, imem_wdata, 3 + i, 32'hCC10_8000 + 32'(i));
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        total++;
        if (ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_closed: ld_ready=%b want 0", ld_ready);
        end
        hi = 0; we_extra = 0;
        while (core_rstn === 1'b1 && hi < 300) begin
            hi++;
            tick();
            if (imem_we === 1'b1) we_extra++;
        end
        total++;
        if (hi != 100) begin
            bad++;
            $display("FAIL run_length: core_rstn high %0d cycles want 100", hi);
        end
        total++;
        if (we_extra != 0) begin
            bad++;
            $display("FAIL run_no_write: %0d extra imem_we pulses want 0", we_extra);
        end
        total++;
        if (dump_valid !== 1'b0 || reg_raddr !== 5'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL dump_entry: dv=%b raddr=%0d done=%b want 0 0 0", dump_valid, reg_raddr, done);
        end
    endtask

    task automatic test_dump();
        int n;
        int c;
        n = 0; c = 0;
        dump_ready = 1'b1;
        while (done !== 1'b1 && c < 100) begin
            tick();
            c++;
            if (dump_valid === 1'b1) begin
                total++;
                if (dump_idx !== 5'(n) || dump_data !== 32'(n) * 32'h11) begin
                    bad++;
                    $display("FAIL dump_word[%0d]: idx=%0d data=%h want %0d %h",
                             n, dump_idx, dump_data, n, 32'(n) * 32'h11);
                end
                n++;
            end
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL dump_count: %0d words want 10", n);
        end
        total++;
        if (done !== 1'b1 || dump_valid !== 1'b0 || imem_we !== 1'b0 || core_rstn !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_state: done=%b dv=%b we=%b crst=%b rdy=%b want 1 0 0 0 0",
                     done, dump_valid, imem_we, core_rstn, ld_ready);
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_run_zero();
        do_reset();
        ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'h1234_5678;
        ld_last = 1'b1; run_cycles = 16'd0;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        total++;
        if (imem_we !== 1'b1 || imem_waddr !== 5'd7 || imem_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL zero_write: we=%b addr=%0d data=%h want 1 7 12345678", imem_we, imem_waddr, imem_wdata);
        end
        total++;
        if (core_rstn !== 1'b0 || dump_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_run: core_rstn=%b dv=%b want 0 0", core_rstn, dump_valid);
        end
        tick();
        total++;
        if (core_rstn !== 1'b0 || dump_valid !== 1'b0 || imem_we !== 1'b0) begin
            bad++;
            $display("FAIL zero_dump_entry: core_rstn=%b dv=%b we=%b want 0 0 0", core_rstn, dump_valid, imem_we);
        end
        tick();
        total++;
        if (core_rstn !== 1'b0 || dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            bad++;
            $display("FAIL zero_first_word: crst=%b dv=%b idx=%0d data=%h want 0 1 0 0",
                     core_rstn, dump_valid, dump_idx, dump_data);
        end
    endtask

    // Continues from test_run_zero: word 0 is already being offered.
    task automatic test_dump_stall();
        int exp_idx;
        int stall;
        logic prev_v;
        logic [4:0] held_idx;
        logic [31:0] held_data;
        exp_idx = 0; stall = 0; prev_v = 1'b0;
        held_idx = '0; held_data = '0;
        for (int c = 0; c < 200 && done !== 1'b1; c++) begin
            if (dump_valid === 1'b1) begin
                total++;
                if (!prev_v) begin
                    if (dump_idx !== 5'(exp_idx) || dump_data !== 32'(exp_idx) * 32'h11) begin
                        bad++;
                        $display("FAIL stall_word[%0d]: idx=%0d data=%h want %0d %h",
                                 exp_idx, dump_idx, dump_data, exp_idx, 32'(exp_idx) * 32'h11);
                    end
                    held_idx = dump_idx;
                    held_data = dump_data;
                end else if (dump_idx !== held_idx || dump_data !== held_data) begin
                    bad++;
                    $display("FAIL stall_hold: idx=%0d data=%h want %0d %h",
                             dump_idx, dump_data, held_idx, held_data);
                end
                if (exp_idx == 2 && stall < 7) begin
                    dump_ready = 1'b0;
                    stall++;
                end else begin
                    dump_ready = 1'b1;
                    exp_idx++;
                end
            end else begin
                dump_ready = 1'b0;
            end
            prev_v = dump_valid;
            tick();
        end
        dump_ready = 1'b0;
        total++;
        if (exp_idx != 10 || stall != 7 || done !== 1'b1) begin
            bad++;
            $display("FAIL stall_end: words=%0d stalls=%0d done=%b want 10 7 1", exp_idx, stall, done);
        end
    endtask

    task automatic test_bad_addr();
        logic [5:0] addrs [5];
        logic       exp_we [5];
        addrs = '{6'd40, 6'd31, 6'd32, 6'd63, 6'd0};
        exp_we = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        RSTN_N = 1'b0;
        #2;
        total++;
        if (done !== 1'b0 || dump_data !== 32'd0 || dump_idx !== 5'd0 || dump_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_from_done: done=%b data=%h idx=%0d dv=%b want 0 0 0 0",
                     done, dump_data, dump_idx, dump_valid);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_addr = addrs[i]; ld_data = 32'hA500_0000 + 32'(i); ld_last = 1'b0;
            total++;
            if (ld_ready !== 1'b1) begin
                bad++;
                $display("FAIL addr_ready[%0d]: ld_ready=%b want 1", addrs[i], ld_ready);
            end
            tick();
            total++;
            if (imem_we !== exp_we[i] || (exp_we[i] && (imem_waddr !== addrs[i][4:0] || imem_wdata !== 32'hA500_0000 + 32'(i)))) begin
                bad++;
                $display("FAIL addr_write[%0d]: we=%b addr=%0d data=%h want we=%b",
                         addrs[i], imem_we, imem_waddr, imem_wdata, exp_we[i]);
            end
        end
        ld_valid = 1'b0;
        tick();
        total++;
        if (imem_we !== 1'b0 || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL addr_idle: we=%b ld_ready=%b want 0 1", imem_we, ld_ready);
        end
    endtask

    task automatic test_abort();
        int hi;
`ifdef DBG_LOADER_CLEAR_EN
        int writes;
        int c;
        bit ok;
`endif
        do_reset();
        ld_valid = 1'b1; ld_addr = 6'd9; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1; run_cycles = 16'd200;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (50) tick();
        total++;
        if (core_rstn !== 1'b1) begin
            bad++;
            $display("FAIL abort_running: core_rstn=%b at run cycle 50 want 1", core_rstn);
        end
        RSTN_N = 1'b0;
        #1;
        total++;
        if (core_rstn !== 1'b0 || ld_ready !== 1'b0 || imem_we !== 1'b0 || imem_waddr !== 5'd0 || imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL abort_immediate: crst=%b rdy=%b we=%b addr=%0d data=%h want 0 0 0 0 0",
                     core_rstn, ld_ready, imem_we, imem_waddr, imem_wdata);
        end
        tick();
        RSTN_N = 1'b1;
`ifdef DBG_LOADER_CLEAR_EN
        writes = 0; c = 0; ok = 1'b1;
        while (ld_ready !== 1'b1 && c < 100) begin
            tick();
            c++;
            if (imem_we === 1'b1) begin
                if (imem_waddr !== 5'(writes) || imem_wdata !== 32'd0) ok = 1'b0;
                writes++;
            end
            if (core_rstn !== 1'b0) ok = 1'b0;
        end
        total++;
        if (writes != 32 || !ok || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_writes: writes=%0d order_ok=%0d ld_ready=%b want 32 1 1", writes, ok, ld_ready);
        end
`else
        tick();
        total++;
        if (ld_ready !== 1'b1 || imem_we !== 1'b0 || core_rstn !== 1'b0) begin
            bad++;
            $display("FAIL abort_reload: rdy=%b we=%b crst=%b want 1 0 0", ld_ready, imem_we, core_rstn);
        end
`endif
        ld_valid = 1'b1; ld_addr = 6'd2; ld_data = 32'h0000_0013; ld_last = 1'b1; run_cycles = 16'd3;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        hi = 0;
        while (core_rstn === 1'b1 && hi < 300) begin
            hi++;
            tick();
        end
        total++;
        if (hi != 3) begin
            bad++;
            $display("FAIL abort_new_run: core_rstn high %0d cycles want 3", hi);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_run();
        test_dump();
        test_run_zero();
        test_dump_stall();
        test_bad_addr();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
